tb_dina_mapper: RTL and testbench

- Parametrised write-data mapper for the temporary-buffer (TB) port A in the EKF-SLAM datapath. Sits between the TB data sources (CB read port, non-linear unit, further sources) and the TB write port.
- Selects one of NSRC L-lane sources and applies a lane mapping: pass, reverse, segment placement, rotate, or multi-cycle packing.
- Drives registered write data, a per-lane write-enable mask and a valid strobe.

---
 rtl/tb_dina_mapper_if.sv | 34 +++
 rtl/tb_dina_mapper.sv | 190 +++++++++++++++++++
 tb/tb_tb_dina_mapper.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tb_dina_mapper_if.sv
// Request/response bundle between the TB write-data sources and the TB port-A mapper.
// The master side issues mapping requests; the slave side returns mapped write data.
interface tb_dina_mapper_if #(
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int NSRC   = 2,
    parameter int SEG    = 2
);
    localparam int NSEG = L / SEG;
    localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int OW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    logic                       in_valid;
    logic [SW-1:0]              src_sel;
    logic [2:0]                 mode;
    logic [OW-1:0]              seg_off;
    logic                       flush;
    logic [NSRC*L*RSA_DW-1:0]   src_data;
    logic [L*RSA_DW-1:0]        TB_dina;
    logic [L-1:0]               TB_wea;
    logic                       out_valid;
    logic                       map_err;
    logic [OW:0]                pack_cnt;

    modport master (
        output in_valid, src_sel, mode, seg_off, flush, src_data,
        input  TB_dina, TB_wea, out_valid, map_err, pack_cnt
    );

    modport slave (
        input  in_valid, src_sel, mode, seg_off, flush, src_data,
        output TB_dina, TB_wea, out_valid, map_err, pack_cnt
    );
endinterface

// File: rtl/tb_dina_mapper.sv
// TB port-A write-data mapper: selects one L-lane source and applies pass/reverse/
// segment-place/rotate/pack mapping, producing registered data, lane enables and valid.
module tb_dina_mapper #(
    parameter int L      = 4,
    parameter int RSA_DW = 16,
    parameter int NSRC   = 2,
    parameter int SEG    = 2
) (
    input  logic             clk,
    input  logic             sys_rst,
    tb_dina_mapper_if.slave  bus
);
    localparam int LW   = L * RSA_DW;
    localparam int NSEG = L / SEG;
    localparam int SW   = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam int OW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    localparam logic [2:0] M_IDLE = 3'd0;
    localparam logic [2:0] M_POS  = 3'd1;
    localparam logic [2:0] M_NEG  = 3'd2;
    localparam logic [2:0] M_NEW  = 3'd3;
    localparam logic [2:0] M_ROT  = 3'd4;
    localparam logic [2:0] M_PACK = 3'd5;

    logic [LW-1:0] r_dina;
    logic [LW-1:0] w_dina_nxt;
    logic [LW-1:0] r_acc;
    logic [LW-1:0] w_acc_nxt;
    logic [LW-1:0] w_acc_frag;
    logic [LW-1:0] w_src;
    logic [L-1:0]  r_wea;
    logic [L-1:0]  w_wea_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_err;
    logic          w_err_nxt;
    logic [OW:0]   r_cnt;
    logic [OW:0]   w_cnt_nxt;
    logic [OW:0]   w_cnt_inc;
    logic          w_sel_bad;
    logic          w_mode_bad;
    logic          w_off_bad;
    logic          w_illegal;

    // Lane-enable mask covering the first cnt segments (partial or full pack word).
    function automatic logic [L-1:0] fill_mask(input logic [OW:0] cnt);
        logic [L-1:0] m;
        m = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (k < int'(cnt)) begin
                m[k*SEG +: SEG] = {SEG{1'b1}};
            end else begin
                m[k*SEG +: SEG] = {SEG{1'b0}};
            end
        end
        return m;
    endfunction

    // Source select; out-of-range indices yield zero and are flagged separately.
    always_comb begin
        w_src = '0;
        for (int s = 0; s < NSRC; s++) begin
            w_src = w_src | ((bus.src_sel == SW'(s)) ? bus.src_data[s*LW +: LW] : {LW{1'b0}});
        end
    end

    // Request legality checks.
    always_comb begin
        w_sel_bad  = ({1'b0, bus.src_sel} >= (SW+1)'(NSRC));
        w_mode_bad = (bus.mode > M_PACK);
        w_off_bad  = ({1'b0, bus.seg_off} >= (OW+1)'(NSEG));
        w_illegal  = bus.in_valid & (w_sel_bad | w_mode_bad | w_off_bad);
        w_cnt_inc  = r_cnt + (OW+1)'(1);
    end

    // Accumulator with the current fragment appended at segment r_cnt.
    always_comb begin
        w_acc_frag = r_acc;
        for (int j = 0; j < SEG; j++) begin
            w_acc_frag[(int'(r_cnt)*SEG + j)*RSA_DW +: RSA_DW] = w_src[j*RSA_DW +: RSA_DW];
        end
    end

    // Next-state for output registers and pack state.
    always_comb begin
        w_dina_nxt  = r_dina;
        w_wea_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_cnt_nxt   = r_cnt;
        w_acc_nxt   = r_acc;
        if (bus.in_valid) begin
            w_valid_nxt = 1'b1;
            // Leaving PACK with fragments held drops them and reports it.
            if ((bus.mode != M_PACK) && (r_cnt != '0)) begin
                w_cnt_nxt = '0;
                w_acc_nxt = '0;
                w_err_nxt = 1'b1;
            end else begin
                w_err_nxt = 1'b0;
            end
            if (w_illegal) begin
                w_dina_nxt = '0;
                w_wea_nxt  = '0;
                w_err_nxt  = 1'b1;
            end else begin
                case (bus.mode)
                    M_IDLE: begin
                        w_dina_nxt = '0;
                        w_wea_nxt  = '0;
                    end
                    M_POS: begin
                        w_dina_nxt = w_src;
                        w_wea_nxt  = '1;
                    end
                    M_NEG: begin
                        for (int i = 0; i < L; i++) begin
                            w_dina_nxt[i*RSA_DW +: RSA_DW] = w_src[(L-1-i)*RSA_DW +: RSA_DW];
                        end
                        w_wea_nxt = '1;
                    end
                    M_NEW: begin
                        w_dina_nxt = '0;
                        for (int j = 0; j < SEG; j++) begin
                            w_dina_nxt[(int'(bus.seg_off)*SEG + j)*RSA_DW +: RSA_DW] = w_src[j*RSA_DW +: RSA_DW];
                            w_wea_nxt[int'(bus.seg_off)*SEG + j] = 1'b1;
                        end
                    end
                    M_ROT: begin
                        for (int i = 0; i < L; i++) begin
                            w_dina_nxt[i*RSA_DW +: RSA_DW] =
                                w_src[((i + int'(bus.seg_off)*SEG) % L)*RSA_DW +: RSA_DW];
                        end
                        w_wea_nxt = '1;
                    end
                    M_PACK: begin
                        if ((w_cnt_inc == (OW+1)'(NSEG)) || bus.flush) begin
                            w_dina_nxt = w_acc_frag;
                            w_wea_nxt  = fill_mask(w_cnt_inc);
                            w_cnt_nxt  = '0;
                            w_acc_nxt  = '0;
                        end else begin
                            w_valid_nxt = 1'b0;
                            w_acc_nxt   = w_acc_frag;
                            w_cnt_nxt   = w_cnt_inc;
                        end
                    end
                    default: begin
                        w_dina_nxt = '0;
                        w_wea_nxt  = '0;
                        w_err_nxt  = 1'b1;
                    end
                endcase
            end
        end else if (bus.flush && (r_cnt != '0)) begin
            w_valid_nxt = 1'b1;
            w_dina_nxt  = r_acc;
            w_wea_nxt   = fill_mask(r_cnt);
            w_cnt_nxt   = '0;
            w_acc_nxt   = '0;
        end else begin
            w_valid_nxt = 1'b0;
        end
    end

    // Output and pack-state registers.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            r_dina  <= '0;
            r_wea   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
        end else begin
            r_dina  <= w_dina_nxt;
            r_wea   <= w_wea_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
            r_acc   <= w_acc_nxt;
        end
    end

    assign bus.TB_dina   = r_dina;
    assign bus.TB_wea    = r_wea;
    assign bus.out_valid = r_valid;
    assign bus.map_err   = r_err;
    assign bus.pack_cnt  = r_cnt;
endmodule

// File: tb/tb_tb_dina_mapper.sv
// Scoreboard bench for tb_dina_mapper (L=4, 16-bit lanes, 3 sources so that
// src_sel=3 is an out-of-range index).
module tb_tb_dina_mapper;
    localparam int L = 4, DW = 16, NSRC = 3, SEG = 2;

    typedef struct {
        logic [63:0] dina;
        logic [3:0]  wea;
        logic        v;
        logic        err;
        logic [1:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [63:0] srcs [3];
    logic [63:0] held;
    exp_t        sb [$];
    exp_t        e;
    int          n_checks = 0;
    int          n_errors = 0;

    tb_dina_mapper_if #(.L(L), .RSA_DW(DW), .NSRC(NSRC), .SEG(SEG)) bus ();

    tb_dina_mapper #(.L(L), .RSA_DW(DW), .NSRC(NSRC), .SEG(SEG)) dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Apply one request on a falling edge; outputs for it are visible at the next falling edge.
    task automatic drive(input logic v, input logic [1:0] sel, input logic [2:0] md,
                         input logic off, input logic fl);
        bus.in_valid = v;
        bus.src_sel  = sel;
        bus.mode     = md;
        bus.seg_off  = off;
        bus.flush    = fl;
        bus.src_data = {srcs[2], srcs[1], srcs[0]};
        @(negedge clk);
    endtask

    task automatic push(input logic [63:0] d, input logic [3:0] w, input logic v,
                        input logic er, input logic [1:0] c);
        exp_t x;
        x.dina = v ? d : held;
        x.wea  = w;
        x.v    = v;
        x.err  = er;
        x.cnt  = c;
        if (v) held = d;
        sb.push_back(x);
    endtask

    function automatic logic [63:0] ref_map(input logic [2:0] md, input logic off,
                                            input logic [63:0] s, output logic [3:0] w);
        logic [15:0] ln [4];
        logic [63:0] r;
        for (int i = 0; i < 4; i++) ln[i] = s[16*i +: 16];
        r = 64'h0;
        w = 4'b1111;
        case (md)
            3'd2: for (int i = 0; i < 4; i++) r[16*i +: 16] = ln[3-i];
            3'd3: begin
                r[16*(2*int'(off)) +: 16]     = ln[0];
                r[16*(2*int'(off) + 1) +: 16] = ln[1];
                w = off ? 4'b1100 : 4'b0011;
            end
            3'd4: for (int i = 0; i < 4; i++) r[16*i +: 16] = ln[(i + 2*int'(off)) % 4];
            default: r = s;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        sys_rst = 1'b1;
        srcs[0] = 64'h1234_5678_9ABC_DEF0;
        drive(1'b1, 2'd0, 3'd1, 1'b0, 1'b0);
        held = 64'h0;
        push(64'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        sys_rst = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt} !== {e.dina, e.wea, e.v, e.err, e.cnt}) begin
            n_errors++;
            $display("FAIL reset: got dina=%h wea=%b v=%b err=%b cnt=%0d, exp dina=%h wea=%b v=%b err=%b cnt=%0d",
                     bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt, e.dina, e.wea, e.v, e.err, e.cnt);
        end
    endtask

    task automatic test_basic_modes();
        // POS, then an idle cycle that must hold data
        srcs[0] = 64'h0004_0003_0002_0001;
        srcs[1] = 64'hAAAA_BBBB_CCCC_DDDD;
        srcs[2] = 64'h5555_6666_7777_8888;
        drive(1'b1, 2'd0, 3'd1, 1'b0, 1'b0); push(64'h0004_0003_0002_0001, 4'hF, 1'b1, 1'b0, 2'd0);
        e = sb.pop_front(); n_checks++;
        if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err} !== {e.dina, e.wea, e.v, e.err}) begin
            n_errors++;
            $display("FAIL pos: got dina=%h wea=%b v=%b err=%b, exp dina=%h wea=%b v=%b err=%b",
                     bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, e.dina, e.wea, e.v, e.err);
        end
        drive(1'b0, 2'd0, 3'd1, 1'b0, 1'b0); push(64'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        e = sb.pop_front(); n_checks++;
        if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err} !== {e.dina, e.wea, e.v, e.err}) begin
            n_errors++;
            $display("FAIL hold: got dina=%h wea=%b v=%b err=%b, exp dina=%h wea=%b v=%b err=%b",
                     bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, e.dina, e.wea, e.v, e.err);
        end
        drive(1'b1, 2'd1, 3'd2, 1'b0, 1'b0); push(64'hDDDD_CCCC_BBBB_AAAA, 4'hF, 1'b1, 1'b0, 2'd0);
        srcs[0] = 64'h9999_8888_1111_2222;
        drive(1'b1, 2'd0, 3'd3, 1'b1, 1'b0); push(64'h1111_2222_0000_0000, 4'hC, 1'b1, 1'b0, 2'd0);
        drive(1'b1, 2'd0, 3'd3, 1'b0, 1'b0); push(64'h0000_0000_1111_2222, 4'h3, 1'b1, 1'b0, 2'd0);
        srcs[0] = 64'h0004_0003_0002_0001;
        drive(1'b1, 2'd0, 3'd4, 1'b1, 1'b0); push(64'h0002_0001_0004_0003, 4'hF, 1'b1, 1'b0, 2'd0);
        drive(1'b1, 2'd0, 3'd0, 1'b0, 1'b0); push(64'h0, 4'h0, 1'b1, 1'b0, 2'd0);
        // Last five results were pushed one per cycle but each cycle overwrote the
        // outputs; only compare as we go, so re-run them individually below.
        sb.delete();
    endtask

    task automatic test_map_each();
        logic [2:0] md [5];
        logic [1:0] sel [5];
        logic       off [5];
        logic [63:0] dat [5];
        logic [63:0] exd [5];
        logic [3:0]  exw [5];
        md  = '{3'd2, 3'd3, 3'd3, 3'd4, 3'd0};
        sel = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        off = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        dat = '{64'hAAAA_BBBB_CCCC_DDDD, 64'h9999_8888_1111_2222, 64'h9999_8888_1111_2222,
                64'h0004_0003_0002_0001, 64'hFFFF_FFFF_FFFF_FFFF};
        exd = '{64'hDDDD_CCCC_BBBB_AAAA, 64'h1111_2222_0000_0000, 64'h0000_0000_1111_2222,
                64'h0002_0001_0004_0003, 64'h0};
        exw = '{4'hF, 4'hC, 4'h3, 4'hF, 4'h0};
        for (int k = 0; k < 5; k++) begin
            srcs[sel[k]] = dat[k];
            drive(1'b1, sel[k], md[k], off[k], 1'b0);
            push(exd[k], exw[k], 1'b1, 1'b0, 2'd0);
            e = sb.pop_front(); n_checks++;
            if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err} !== {e.dina, e.wea, e.v, e.err}) begin
                n_errors++;
                $display("FAIL map_mode%0d: got dina=%h wea=%b v=%b err=%b, exp dina=%h wea=%b v=%b err=%b",
                         md[k], bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, e.dina, e.wea, e.v, e.err);
            end
        end
    endtask

    task automatic test_pack();
        // full word, flush alone, flush with fragment, flush with nothing held
        logic        iv  [6];
        logic        fl  [6];
        logic [63:0] dat [6];
        logic [63:0] exd [6];
        logic [3:0]  exw [6];
        logic        exv [6];
        logic [1:0]  exc [6];
        iv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        fl  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        dat = '{64'hFFFF_EEEE_00B0_00A0, 64'h1234_5678_00D0_00C0, 64'hFFFF_EEEE_00B0_00A0,
                64'h0, 64'hFFFF_EEEE_00B0_00A0, 64'h0};
        exd = '{64'h0, 64'h00D0_00C0_00B0_00A0, 64'h0, 64'h0000_0000_00B0_00A0,
                64'h0000_0000_00B0_00A0, 64'h0};
        exw = '{4'h0, 4'hF, 4'h0, 4'h3, 4'h3, 4'h0};
        exv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exc = '{2'd1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
        for (int k = 0; k < 6; k++) begin
            srcs[0] = dat[k];
            drive(iv[k], 2'd0, 3'd5, 1'b0, fl[k]);
            push(exd[k], exw[k], exv[k], 1'b0, exc[k]);
            e = sb.pop_front(); n_checks++;
            if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt} !== {e.dina, e.wea, e.v, e.err, e.cnt}) begin
                n_errors++;
                $display("FAIL pack_step%0d: got dina=%h wea=%b v=%b err=%b cnt=%0d, exp dina=%h wea=%b v=%b err=%b cnt=%0d",
                         k, bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt,
                         e.dina, e.wea, e.v, e.err, e.cnt);
            end
        end
    endtask

    task automatic test_mode_change_and_illegal();
        logic        iv  [9];
        logic [1:0]  sel [9];
        logic [2:0]  md  [9];
        logic [63:0] dat [9];
        logic [63:0] exd [9];
        logic [3:0]  exw [9];
        logic        exv [9];
        logic        exe [9];
        logic [1:0]  exc [9];
        // frag, POS mid-pack, idle, bad src, mode 6, frag, bad-src PACK, frag (completes), frag+mode 7
        iv  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        sel = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
        md  = '{3'd5, 3'd1, 3'd1, 3'd1, 3'd6, 3'd5, 3'd5, 3'd5, 3'd5};
        dat = '{64'h0000_0000_00B0_00A0, 64'h0004_0003_0002_0001, 64'h0, 64'h7777_7777_7777_7777,
                64'h7777_7777_7777_7777, 64'h0000_0000_00B0_00A0, 64'h7777_7777_7777_7777,
                64'h0000_0000_00D0_00C0, 64'h0000_0000_0011_0022};
        exd = '{64'h0, 64'h0004_0003_0002_0001, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0,
                64'h00D0_00C0_00B0_00A0, 64'h0};
        exw = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0};
        exv = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        exe = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exc = '{2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
        for (int k = 0; k < 9; k++) begin
            srcs[0] = dat[k];
            drive(iv[k], sel[k], md[k], 1'b0, 1'b0);
            push(exd[k], exw[k], exv[k], exe[k], exc[k]);
            e = sb.pop_front(); n_checks++;
            if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt} !== {e.dina, e.wea, e.v, e.err, e.cnt}) begin
                n_errors++;
                $display("FAIL err_step%0d: got dina=%h wea=%b v=%b err=%b cnt=%0d, exp dina=%h wea=%b v=%b err=%b cnt=%0d",
                         k, bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt,
                         e.dina, e.wea, e.v, e.err, e.cnt);
            end
        end
        // mode 7 with one fragment held: illegal response, partial discarded
        drive(1'b1, 2'd0, 3'd7, 1'b0, 1'b0);
        push(64'h0, 4'h0, 1'b1, 1'b1, 2'd0);
        e = sb.pop_front(); n_checks++;
        if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt} !== {e.dina, e.wea, e.v, e.err, e.cnt}) begin
            n_errors++;
            $display("FAIL mode7_midpack: got dina=%h wea=%b v=%b err=%b cnt=%0d, exp dina=%h wea=%b v=%b err=%b cnt=%0d",
                     bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt, e.dina, e.wea, e.v, e.err, e.cnt);
        end
    endtask

    task automatic test_reset_midpack();
        srcs[0] = 64'h0000_0000_00B0_00A0;
        drive(1'b1, 2'd0, 3'd5, 1'b0, 1'b0);
        push(64'h0, 4'h0, 1'b0, 1'b0, 2'd1);
        e = sb.pop_front(); n_checks++;
        if (bus.pack_cnt !== e.cnt) begin
            n_errors++;
            $display("FAIL rstpack_pre: got cnt=%0d, exp cnt=%0d", bus.pack_cnt, e.cnt);
        end
        sys_rst = 1'b1;
        srcs[0] = 64'h0004_0003_0002_0001;
        drive(1'b1, 2'd0, 3'd1, 1'b0, 1'b0);
        held = 64'h0;
        push(64'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        sys_rst = 1'b0;
        drive(1'b0, 2'd0, 3'd5, 1'b0, 1'b1);
        push(64'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        drive(1'b0, 2'd0, 3'd5, 1'b0, 1'b0);
        push(64'h0, 4'h0, 1'b0, 1'b0, 2'd0);
        // outputs were sampled only at the last edge; check the final state, then drop the rest
        while (sb.size() > 1) void'(sb.pop_front());
        e = sb.pop_front(); n_checks++;
        if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt} !== {e.dina, e.wea, e.v, e.err, e.cnt}) begin
            n_errors++;
            $display("FAIL rstpack_post: got dina=%h wea=%b v=%b err=%b cnt=%0d, exp dina=%h wea=%b v=%b err=%b cnt=%0d",
                     bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, bus.pack_cnt, e.dina, e.wea, e.v, e.err, e.cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  md;
        logic [1:0]  sel;
        logic        off;
        logic [3:0]  w;
        logic [63:0] d;
        for (int k = 0; k < 24; k++) begin
            for (int s = 0; s < 3; s++) srcs[s] = {$urandom, $urandom};
            md  = 3'($urandom_range(1, 4));
            sel = 2'($urandom_range(0, 2));
            off = 1'($urandom_range(0, 1));
            d   = ref_map(md, off, srcs[sel], w);
            drive(1'b1, sel, md, off, 1'($urandom_range(0, 1)));
            push(d, w, 1'b1, 1'b0, 2'd0);
            e = sb.pop_front(); n_checks++;
            if ({bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err} !== {e.dina, e.wea, e.v, e.err}) begin
                n_errors++;
                $display("FAIL b2b_%0d mode%0d: got dina=%h wea=%b v=%b err=%b, exp dina=%h wea=%b v=%b err=%b",
                         k, md, bus.TB_dina, bus.TB_wea, bus.out_valid, bus.map_err, e.dina, e.wea, e.v, e.err);
            end
        end
    endtask

    initial begin
        srcs[0] = 64'h0; srcs[1] = 64'h0; srcs[2] = 64'h0;
        held = 64'h0;
        bus.in_valid = 1'b0; bus.src_sel = 2'd0; bus.mode = 3'd0;
        bus.seg_off = 1'b0; bus.flush = 1'b0; bus.src_data = '0;
        @(negedge clk);
        test_reset();
        test_basic_modes();
        test_map_each();
        test_pack();
        test_mode_change_and_illegal();
        test_reset_midpack();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
